// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: conversion handshake between the scan sequencer and the ADC controller
interface adc_scan_sequencer_if;
    logic       start_protocol;
    logic [2:0] channel;
    logic [9:0] adc_data;
    logic       adc_ready;
    modport master (output start_protocol, channel, input adc_data, adc_ready);
    modport slave  (input start_protocol, channel, output adc_data, adc_ready);
endinterface

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans ADC channels per frame, averages 2^avg_log2 samples each, stores to a result bank
module adc_scan_sequencer #(
    parameter int TIMEOUT = 63
) (
    input  logic                        clk_doubleSCLK,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [3:0]                  num_channels,
    input  logic [1:0]                  avg_log2,
    adc_scan_sequencer_if.master        adc,
    output logic [9:0]                  sample_out,
    output logic [2:0]                  sample_channel,
    output logic                        sample_valid,
    output logic                        frame_done,
    output logic                        err_timeout,
    output logic                        busy,
    input  logic [2:0]                  rd_addr,
    output logic [9:0]                  rd_data
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, START, WAIT, ACCUM, STORE} state_t;
    state_t state, state_n;
    logic [3:0]    nch_q, nch_eff, cnt;
    logic [1:0]    avg_q;
    logic [2:0]    idx;
    logic [12:0]   acc;
    logic [9:0]    data_q;
    logic [TW-1:0] wcnt;
    logic          rdy_q, rise, tmo, last, more;
    logic [9:0]    bank [8];
    assign nch_eff = num_channels == 4'd0 ? 4'd1 : num_channels > 4'd8 ? 4'd8 : num_channels;
    assign rise = adc.adc_ready & ~rdy_q;
    assign tmo = state == WAIT && !rise && wcnt == TW'(TIMEOUT - 1);
    assign last = {1'b0, idx} == nch_q - 4'd1;
    assign more = (cnt + 4'd1) < (4'd1 << avg_q);
    assign adc.start_protocol = state == START;
    assign adc.channel = idx;
    assign busy = state != IDLE;
    assign sample_valid = state == STORE;
    assign sample_channel = idx;
    assign sample_out = 10'(acc >> avg_q);
    // a timed-out channel still closes the frame when it is the last one
    assign frame_done = (sample_valid || tmo) && last;
    assign rd_data = bank[rd_addr];
    always_ff @(posedge clk_doubleSCLK or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = enable ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = rise ? ACCUM : tmo ? (last && !enable ? IDLE : START) : WAIT;
            ACCUM:   state_n = more ? START : STORE;
            STORE:   state_n = last && !enable ? IDLE : START;
            default: state_n = IDLE;
        endcase
    end
    // rdy_q resets high so a level already high at reset is not taken as a new conversion
    always_ff @(posedge clk_doubleSCLK or posedge reset)
        if (reset) begin
            rdy_q       <= 1'b1;
            nch_q       <= 4'd0;
            avg_q       <= 2'd0;
            idx         <= 3'd0;
            acc         <= 13'd0;
            cnt         <= 4'd0;
            data_q      <= 10'd0;
            wcnt        <= '0;
            err_timeout <= 1'b0;
            bank        <= '{default: '0};
        end else begin
            rdy_q <= adc.adc_ready;
            if (state == IDLE && enable) begin
                nch_q       <= nch_eff;
                avg_q       <= avg_log2;
                idx         <= 3'd0;
                acc         <= 13'd0;
                cnt         <= 4'd0;
                err_timeout <= 1'b0;
            end
            if (state == START) wcnt <= '0;
            if (state == WAIT) begin
                if (rise) data_q <= adc.adc_data;
                else wcnt <= wcnt + TW'(1);
            end
            if (state == ACCUM) begin
                acc <= acc + 13'(data_q);
                cnt <= cnt + 4'd1;
            end
            if (state == STORE) bank[idx] <= sample_out;
            if (tmo) err_timeout <= 1'b1;
            if (sample_valid || tmo) begin
                acc <= 13'd0;
                cnt <= 4'd0;
                idx <= last ? 3'd0 : idx + 3'd1;
                if (last) begin
                    nch_q <= nch_eff;
                    avg_q <= avg_log2;
                end
            end
        end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed scenarios against a simple ADC controller model
module tb_adc_scan_sequencer;
    logic clk_doubleSCLK = 0, reset = 1, enable = 0;
    logic [3:0] num_channels = 0;
    logic [1:0] avg_log2 = 0;
    logic [2:0] rd_addr = 0;
    logic [9:0] sample_out, rd_data;
    logic [2:0] sample_channel;
    logic sample_valid, frame_done, err_timeout, busy;
    logic model_rdy = 0, force_rdy = 0;
    logic [9:0] model_data = 0;
    logic [2:0] pend = 0;
    int mode = 0, pcnt = 0, pbase = 0, dly = 0, hold = 0;
    int cyc = 0, nstart = 0, nvalid = 0, nframe = 0, st1 = 0, fd = 0;
    int tests = 0, fails = 0;
    int q_ch[$], q_val[$];
    adc_scan_sequencer_if adc();
    assign adc.adc_ready = model_rdy | force_rdy;
    assign adc.adc_data = model_data;
    adc_scan_sequencer dut (
        .clk_doubleSCLK(clk_doubleSCLK), .reset(reset), .enable(enable),
        .num_channels(num_channels), .avg_log2(avg_log2), .adc(adc),
        .sample_out(sample_out), .sample_channel(sample_channel), .sample_valid(sample_valid),
        .frame_done(frame_done), .err_timeout(err_timeout), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );
    always #5 clk_doubleSCLK = ~clk_doubleSCLK;
    // controller model: data_ready rises 4 cycles after start, held 2 cycles; mode 3 never answers ch1
    always @(negedge clk_doubleSCLK) begin
        if (reset) begin
            dly = 0; hold = 0; model_rdy = 0;
        end else begin
            if (hold > 0) begin hold--; if (hold == 0) model_rdy = 0; end
            if (adc.start_protocol) begin pend = adc.channel; pcnt++; dly = 4; end
            else if (dly > 0) begin
                dly--;
                if (dly == 0 && !(mode == 3 && pend == 1)) begin
                    model_data = mode == 2 ? 10'd1023 : mode == 1 ? 10'(9 + pcnt - pbase) : 10'(100 + pend);
                    model_rdy = 1; hold = 2;
                end
            end
        end
    end
    always @(negedge clk_doubleSCLK) begin
        cyc++;
        if (adc.start_protocol) begin nstart++; if (adc.channel == 3'd1) st1 = cyc; end
        if (sample_valid) begin nvalid++; q_ch.push_back(int'(sample_channel)); q_val.push_back(int'(sample_out)); end
        if (frame_done) begin nframe++; fd = cyc; end
    end
    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk_doubleSCLK); #1; ok = !busy; end
    endtask
    task automatic run_frame(input logic [3:0] n, input logic [1:0] a, input int m, output bit ok);
        num_channels = n; avg_log2 = a; mode = m; pbase = pcnt;
        enable = 1;
        repeat (2) @(negedge clk_doubleSCLK);
        #1 enable = 0;
        wait_idle(ok);
    endtask
    task automatic test_reset;
        int v0, f0, q0;
        bit ok;
        force_rdy = 1; reset = 1;
        repeat (3) @(negedge clk_doubleSCLK);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (adc.start_protocol !== 1'b0) begin fails++; $display("FAIL reset_start: got %0b want 0", adc.start_protocol); end
        tests++; if (adc.channel !== 3'd0) begin fails++; $display("FAIL reset_channel: got %0d want 0", adc.channel); end
        tests++; if (sample_valid !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL reset_pulses: got %0b%0b want 00", sample_valid, frame_done); end
        tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", err_timeout); end
        tests++; if (sample_out !== 10'd0 || sample_channel !== 3'd0) begin fails++; $display("FAIL reset_sample: got %0d/%0d want 0/0", sample_out, sample_channel); end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a); #1;
            tests++; if (rd_data !== 10'd0) begin fails++; $display("FAIL reset_bank%0d: got %0d want 0", a, rd_data); end
        end
        num_channels = 1; avg_log2 = 0; mode = 0; pbase = pcnt; enable = 1;
        v0 = nvalid; f0 = nframe; q0 = q_val.size();
        reset = 0;
        repeat (2) @(negedge clk_doubleSCLK);
        #1 force_rdy = 0; enable = 0;
        wait_idle(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stale_ready_idle: got %0b want 1", ok); end
        tests++; if (nvalid - v0 !== 1) begin fails++; $display("FAIL stale_ready_count: got %0d want 1", nvalid - v0); end
        tests++; if (q_val[q0] !== 100) begin fails++; $display("FAIL stale_ready_value: got %0d want 100", q_val[q0]); end
        tests++; if (nframe - f0 !== 1) begin fails++; $display("FAIL stale_ready_frame: got %0d want 1", nframe - f0); end
    endtask
    task automatic test_basic_scan;
        int v0 = nvalid, f0 = nframe, q0 = q_val.size();
        bit ok;
        run_frame(4'd3, 2'd0, 0, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_idle: got %0b want 1", ok); end
        tests++; if (nvalid - v0 !== 3) begin fails++; $display("FAIL basic_count: got %0d want 3", nvalid - v0); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (q_ch[q0+i] !== i || q_val[q0+i] !== 100 + i) begin fails++; $display("FAIL basic_sample%0d: got ch%0d=%0d want ch%0d=%0d", i, q_ch[q0+i], q_val[q0+i], i, 100 + i); end
        end
        tests++; if (nframe - f0 !== 1) begin fails++; $display("FAIL basic_frame: got %0d want 1", nframe - f0); end
        rd_addr = 3'd2; #1;
        tests++; if (rd_data !== 10'd102) begin fails++; $display("FAIL basic_rd2: got %0d want 102", rd_data); end
    endtask
    task automatic test_average;
        int v0 = nvalid, s0 = nstart, q0 = q_val.size();
        bit ok;
        run_frame(4'd1, 2'd2, 1, ok);
        tests++; if (nvalid - v0 !== 1) begin fails++; $display("FAIL avg_count: got %0d want 1", nvalid - v0); end
        tests++; if (q_val[q0] !== 11) begin fails++; $display("FAIL avg_value: got %0d want 11", q_val[q0]); end
        tests++; if (nstart - s0 !== 4) begin fails++; $display("FAIL avg_starts: got %0d want 4", nstart - s0); end
    endtask
    task automatic test_full_scale;
        int v0 = nvalid, s0 = nstart, q0 = q_val.size();
        bit ok;
        run_frame(4'd1, 2'd3, 2, ok);
        tests++; if (nvalid - v0 !== 1 || q_val[q0] !== 1023) begin fails++; $display("FAIL full_value: got %0d samples last=%0d want 1 sample 1023", nvalid - v0, q_val[q0]); end
        tests++; if (nstart - s0 !== 8) begin fails++; $display("FAIL full_starts: got %0d want 8", nstart - s0); end
        rd_addr = 3'd0; #1;
        tests++; if (rd_data !== 10'd1023) begin fails++; $display("FAIL full_rd0: got %0d want 1023", rd_data); end
    endtask
    task automatic test_timeout;
        int v0 = nvalid, f0 = nframe, q0 = q_val.size();
        bit ok;
        run_frame(4'd2, 2'd0, 3, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL tmo_idle: got %0b want 1", ok); end
        tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL tmo_err: got %0b want 1", err_timeout); end
        tests++; if (nvalid - v0 !== 1 || q_ch[q0] !== 0 || q_val[q0] !== 100) begin fails++; $display("FAIL tmo_samples: got %0d ch%0d=%0d want 1 ch0=100", nvalid - v0, q_ch[q0], q_val[q0]); end
        tests++; if (nframe - f0 !== 1) begin fails++; $display("FAIL tmo_frame: got %0d want 1", nframe - f0); end
        tests++; if (fd - st1 !== 63) begin fails++; $display("FAIL tmo_cycles: got %0d want 63", fd - st1); end
        rd_addr = 3'd1; #1;
        tests++; if (rd_data !== 10'd101) begin fails++; $display("FAIL tmo_bank1: got %0d want 101", rd_data); end
    endtask
    task automatic test_err_clear;
        int q0 = q_val.size();
        bit ok;
        run_frame(4'd1, 2'd0, 0, ok);
        tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL errclr_err: got %0b want 0", err_timeout); end
        tests++; if (q_val[q0] !== 100) begin fails++; $display("FAIL errclr_value: got %0d want 100", q_val[q0]); end
    endtask
    task automatic test_enable_drop;
        int v0 = nvalid, f0 = nframe, q0 = q_val.size();
        bit ok;
        run_frame(4'd4, 2'd0, 0, ok);
        tests++; if (nvalid - v0 !== 4) begin fails++; $display("FAIL drop_count: got %0d want 4", nvalid - v0); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (q_ch[q0+i] !== i || q_val[q0+i] !== 100 + i) begin fails++; $display("FAIL drop_sample%0d: got ch%0d=%0d want ch%0d=%0d", i, q_ch[q0+i], q_val[q0+i], i, 100 + i); end
        end
        tests++; if (nframe - f0 !== 1 || busy !== 1'b0) begin fails++; $display("FAIL drop_end: got frames=%0d busy=%0b want 1/0", nframe - f0, busy); end
    endtask
    task automatic test_clamp;
        int v0 = nvalid, q0 = q_val.size();
        bit ok;
        run_frame(4'd12, 2'd0, 0, ok);
        tests++; if (nvalid - v0 !== 8) begin fails++; $display("FAIL clamp_hi_count: got %0d want 8", nvalid - v0); end
        tests++; if (q_ch[q0+7] !== 7 || q_val[q0+7] !== 107) begin fails++; $display("FAIL clamp_hi_last: got ch%0d=%0d want ch7=107", q_ch[q0+7], q_val[q0+7]); end
        v0 = nvalid;
        run_frame(4'd0, 2'd0, 0, ok);
        tests++; if (nvalid - v0 !== 1) begin fails++; $display("FAIL clamp_zero_count: got %0d want 1", nvalid - v0); end
    endtask
    task automatic test_back_to_back;
        int v0 = nvalid, f0 = nframe, q0 = q_val.size();
        bit ok, seen = 0;
        num_channels = 2; avg_log2 = 0; mode = 0; pbase = pcnt; enable = 1;
        for (int i = 0; i < 2000 && !seen; i++) begin @(negedge clk_doubleSCLK); #1; seen = nframe - f0 >= 2; end
        enable = 0;
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL b2b_two_frames: got %0b want 1", seen); end
        wait_idle(ok);
        tests++; if (nframe - f0 !== 2 || nvalid - v0 !== 4) begin fails++; $display("FAIL b2b_counts: got %0d frames %0d samples want 2/4", nframe - f0, nvalid - v0); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (q_ch[q0+i] !== i % 2) begin fails++; $display("FAIL b2b_ch%0d: got %0d want %0d", i, q_ch[q0+i], i % 2); end
        end
    endtask
    task automatic test_reset_mid;
        int v0 = nvalid;
        num_channels = 1; avg_log2 = 0; mode = 0; enable = 1;
        repeat (3) @(negedge clk_doubleSCLK);
        #1 reset = 1;
        #1;
        tests++; if (busy !== 1'b0 || adc.start_protocol !== 1'b0) begin fails++; $display("FAIL rstmid_async: got busy=%0b start=%0b want 0/0", busy, adc.start_protocol); end
        rd_addr = 3'd0; #1;
        tests++; if (rd_data !== 10'd0) begin fails++; $display("FAIL rstmid_bank0: got %0d want 0", rd_data); end
        repeat (8) @(negedge clk_doubleSCLK);
        enable = 0;
        #1 reset = 0;
        repeat (3) @(negedge clk_doubleSCLK);
        #1;
        tests++; if (nvalid - v0 !== 0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_quiet: got %0d samples busy=%0b want 0/0", nvalid - v0, busy); end
    endtask
    initial begin
        test_reset();
        test_basic_scan();
        test_average();
        test_full_scale();
        test_timeout();
        test_err_clear();
        test_enable_drop();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
